fp_nr_sub_stage: RTL and testbench

//  Parametrised Newton-Raphson "1.5 - x" subtract stage of the inverse-sqrt datapath.

---
 rtl/fp_nr_sub_stage_if.sv | 31 +++
 rtl/fp_nr_sub_stage.sv | 110 +++++++++++
 tb/tb_fp_nr_sub_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_nr_sub_stage_if.sv
// Handshake bundle for the Newton-Raphson "1.5 - x" stage: upstream beat in, downstream beat out.
interface fp_nr_sub_stage_if #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned RND_W  = 3,
    parameter int unsigned DLY_W  = 31,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned W = MANT_W + RND_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W+1:0] float_in;
    logic [DLY_W-1:0]  float_in_delay;
    logic              error_in;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      m_sub;
    logic [DLY_W-1:0]  float_out_delay;
    logic              error_out;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, float_in, float_in_delay, error_in, out_ready,
        input  in_ready, out_valid, m_sub, float_out_delay, error_out, err_cnt
    );

    modport slave (
        input  in_valid, float_in, float_in_delay, error_in, out_ready,
        output in_ready, out_valid, m_sub, float_out_delay, error_out, err_cnt
    );
endinterface

// File: rtl/fp_nr_sub_stage.sv
// Inverse-sqrt Newton-Raphson stage: aligns the mantissa by E_sel and computes 1.5 - x,
// with valid/ready backpressure through a one-entry skid buffer and a saturating error counter.
module fp_nr_sub_stage #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned RND_W  = 3,
    parameter int unsigned DLY_W  = 31,
    parameter int unsigned CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    fp_nr_sub_stage_if.slave bus
);
    localparam int unsigned W = MANT_W + RND_W + 1;
    localparam logic [W-1:0] C15 = {2'b11, {(W-2){1'b0}}};

    logic [1:0]        e_sel;
    logic [MANT_W-1:0] mant;
    logic [W-1:0]      m_full;
    logic [W-1:0]      m_in;
    logic [W:0]        diff;
    logic              underflow;
    logic [W-1:0]      res_m;
    logic              res_err;

    logic              accept;
    logic              out_free;

    logic              out_vld;
    logic [W-1:0]      out_m;
    logic [DLY_W-1:0]  out_dly;
    logic              out_err;

    logic              skid_full;
    logic [W-1:0]      skid_m;
    logic [DLY_W-1:0]  skid_dly;
    logic              skid_err;

    logic [CNT_W-1:0]  cnt;

    always_comb begin
        e_sel  = bus.float_in[MANT_W+1:MANT_W];
        mant   = bus.float_in[MANT_W-1:0];
        m_full = {1'b1, mant, {RND_W{1'b0}}};
        case (e_sel)
            2'b10:   m_in = m_full >> 1;
            2'b01:   m_in = m_full >> 2;
            default: m_in = m_full;
        endcase
        // The extra top bit of the W+1 bit difference is the borrow, i.e. m_in > 1.5.
        diff      = {1'b0, C15} - {1'b0, m_in};
        underflow = diff[W];
        res_m     = underflow ? '0 : diff[W-1:0];
        res_err   = bus.error_in | underflow;
    end

    always_comb begin
        accept   = bus.in_valid & ~skid_full;
        out_free = ~out_vld | bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_m     <= '0;
            out_dly   <= '0;
            out_err   <= 1'b0;
            skid_full <= 1'b0;
            skid_m    <= '0;
            skid_dly  <= '0;
            skid_err  <= 1'b0;
            cnt       <= '0;
        end else begin
            // in_ready is low whenever the skid is occupied, so draining and accepting never collide.
            if (out_free) begin
                if (skid_full) begin
                    out_vld   <= 1'b1;
                    out_m     <= skid_m;
                    out_dly   <= skid_dly;
                    out_err   <= skid_err;
                    skid_full <= 1'b0;
                end else if (accept) begin
                    out_vld <= 1'b1;
                    out_m   <= res_m;
                    out_dly <= bus.float_in_delay;
                    out_err <= res_err;
                end else begin
                    out_vld <= 1'b0;
                end
            end else if (accept) begin
                skid_full <= 1'b1;
                skid_m    <= res_m;
                skid_dly  <= bus.float_in_delay;
                skid_err  <= res_err;
            end

            if (out_vld && bus.out_ready && out_err && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready        = ~skid_full;
        bus.out_valid       = out_vld;
        bus.m_sub           = out_m;
        bus.float_out_delay = out_dly;
        bus.error_out       = out_err;
        bus.err_cnt         = cnt;
    end
endmodule

// File: tb/tb_fp_nr_sub_stage.sv
// Self-checking bench for fp_nr_sub_stage: directed vector table, stalled burst, reset with
// full buffers and counter saturation on a narrow-counter instance.
module tb_fp_nr_sub_stage;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_nr_sub_stage_if #(.MANT_W(23), .RND_W(3), .DLY_W(31), .CNT_W(16)) bus ();
    fp_nr_sub_stage_if #(.MANT_W(23), .RND_W(3), .DLY_W(31), .CNT_W(2))  bus2 ();

    fp_nr_sub_stage #(.MANT_W(23), .RND_W(3), .DLY_W(31), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fp_nr_sub_stage #(.MANT_W(23), .RND_W(3), .DLY_W(31), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [1:0]  e;
        logic [22:0] m;
        logic        ei;
        logic [26:0] xm;
        logic        xe;
    } vec_t;

    typedef struct packed {
        logic [26:0] m;
        logic [30:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    logic        stall_prev = 1'b0;
    logic [26:0] m_prev;
    logic [30:0] d_prev;
    logic        e_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for the random burst: integer arithmetic on the unshifted 1.26 mantissa.
    function automatic void model(input logic [1:0] e, input logic [22:0] m, input logic ei,
                                  output logic [26:0] xm, output logic xe);
        longint mf;
        mf = (longint'(1) << 26) | (longint'(m) << 3);
        if (e == 2'b10) mf = mf >> 1;
        else if (e == 2'b01) mf = mf >> 2;
        if (mf > longint'('h600_0000)) begin
            xm = '0;
            xe = 1'b1;
        end else begin
            xm = 27'(longint'('h600_0000) - mf);
            xe = ei;
        end
    endfunction

    // Call at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic drive(input logic [1:0] e, input logic [22:0] m, input logic [30:0] dly,
                         input logic ei, input logic [26:0] xm, input logic xe);
        int n = 0;
        exp_t x;
        bus.in_valid       = 1'b1;
        bus.float_in       = {e, m};
        bus.float_in_delay = dly;
        bus.error_in       = ei;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) break;
        end
        check("accept_timeout", 64'(bus.in_ready), 64'd1);
        x.m = xm;
        x.d = dly;
        x.e = xe;
        if (bus.in_ready) sb.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compares each transferring beat with the scoreboard head and
    // checks that a stalled output keeps its data.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (stall_prev && bus.out_valid) begin
                check("hold_m_sub", 64'(bus.m_sub), 64'(m_prev));
                check("hold_delay", 64'(bus.float_out_delay), 64'(d_prev));
                check("hold_error", 64'(bus.error_out), 64'(e_prev));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    check("m_sub", 64'(bus.m_sub), 64'(x.m));
                    check("float_out_delay", 64'(bus.float_out_delay), 64'(x.d));
                    check("error_out", 64'(bus.error_out), 64'(x.e));
                    if (x.e && exp_cnt != 65535) exp_cnt++;
                end
            end
        end
        stall_prev <= !rst && bus.out_valid && !bus.out_ready;
        m_prev     <= bus.m_sub;
        d_prev     <= bus.float_out_delay;
        e_prev     <= bus.error_out;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        logic [1:0]  re;
        logic [22:0] rm;
        logic [26:0] xm;
        logic        xe;

        tbl[0]  = '{2'b10, 23'h00_0000, 1'b0, 27'h400_0000, 1'b0};
        tbl[1]  = '{2'b01, 23'h00_0000, 1'b0, 27'h500_0000, 1'b0};
        tbl[2]  = '{2'b00, 23'h00_0000, 1'b0, 27'h200_0000, 1'b0};
        tbl[3]  = '{2'b11, 23'h00_0000, 1'b0, 27'h200_0000, 1'b0};
        tbl[4]  = '{2'b00, 23'h40_0000, 1'b0, 27'h000_0000, 1'b0};
        tbl[5]  = '{2'b00, 23'h7F_FFFF, 1'b0, 27'h000_0000, 1'b1};
        tbl[6]  = '{2'b10, 23'h7F_FFFF, 1'b1, 27'h200_0004, 1'b1};
        tbl[7]  = '{2'b01, 23'h7F_FFFF, 1'b0, 27'h400_0002, 1'b0};
        tbl[8]  = '{2'b10, 23'h40_0000, 1'b0, 27'h300_0000, 1'b0};
        tbl[9]  = '{2'b11, 23'h20_0000, 1'b0, 27'h100_0000, 1'b0};
        tbl[10] = '{2'b00, 23'h40_0001, 1'b0, 27'h000_0000, 1'b1};

        rst                 = 1'b1;
        bus.in_valid        = 1'b0;
        bus.float_in        = '0;
        bus.float_in_delay  = '0;
        bus.error_in        = 1'b0;
        bus.out_ready       = 1'b1;
        bus2.in_valid       = 1'b0;
        bus2.float_in       = '0;
        bus2.float_in_delay = '0;
        bus2.error_in       = 1'b0;
        bus2.out_ready      = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_m_sub", 64'(bus.m_sub), 64'd0);
        check("rst_delay", 64'(bus.float_out_delay), 64'd0);
        check("rst_error_out", 64'(bus.error_out), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        check("rst_err_cnt2", 64'(bus2.err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors streamed back to back.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].e, tbl[i].m, 31'(16'h0100 + i), tbl[i].ei, tbl[i].xm, tbl[i].xe);
            if (i == 0) begin
                check("latency_out_valid", 64'(bus.out_valid), 64'd1);
                check("latency_m_sub", 64'(bus.m_sub), 64'(tbl[0].xm));
            end
        end
        wait_drain("table");
        check("err_cnt_table", 64'(bus.err_cnt), 64'(exp_cnt));

        // Eight-beat burst with a three-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    re = 2'($urandom_range(0, 3));
                    rm = 23'($urandom);
                    model(re, rm, 1'(i % 3 == 0), xm, xe);
                    drive(re, rm, 31'(16'h0200 + i), 1'(i % 3 == 0), xm, xe);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("in_ready_before_stall", 64'(bus.in_ready), 64'd1);
                @(negedge clk);
                check("in_ready_after_stall", 64'(bus.in_ready), 64'd0);
                @(posedge clk);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("burst");
        check("err_cnt_burst", 64'(bus.err_cnt), 64'(exp_cnt));

        // Fill output register and skid, then reset.
        bus.out_ready = 1'b0;
        drive(2'b10, 23'h0, 31'h300, 1'b0, 27'h400_0000, 1'b0);
        drive(2'b01, 23'h0, 31'h301, 1'b0, 27'h500_0000, 1'b0);
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst2_err_cnt", 64'(bus.err_cnt), 64'd0);
        bus.out_ready = 1'b1;
        drive(tbl[6].e, tbl[6].m, 31'h400, tbl[6].ei, tbl[6].xm, tbl[6].xe);
        wait_drain("post_reset");
        check("err_cnt_post_reset", 64'(bus.err_cnt), 64'd1);

        // Narrow counter instance: underflowing beats, saturates at 3.
        bus2.float_in = {2'b00, 23'h7F_FFFF};
        bus2.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("err_cnt2_two", 64'(bus2.err_cnt), 64'd2);
        bus2.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("err_cnt2_saturate", 64'(bus2.err_cnt), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
